ui_cmd_parse: RTL and testbench
===============================

# ui_cmd_parse

Receive-side command parser for the serial user interface. It consumes characters from the UART receiver and echoes each one toward the response generator. It decodes `*GO`, `*RPaaaa` and `*RCaaaa` commands, issues register-read or start requests, and drives the response-request handshake that produces `-OK`, `-ERR` or data replies. It sits between the UART RX and the response generator inside the UI top level.

## Interface
- `ADDR_WID`, default 16: read-address width; must be a multiple of 4. `ADDR_DIG = ADDR_WID/4` hex digits.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `rx_data`, in, 8: received character.
- `rx_data_rdy`, in, 1: one-cycle strobe; `rx_data` valid.
- `send_char_val`, out, 1: echo-character strobe.
- `send_char`, out, 8: echo character.
- `send_resp_val`, out, 1: response request; level, held until done.
- `send_resp_type`, out, 2: `RESP_OK`=0, `RESP_ERR`=1, `RESP_DATA0`=2 (phi), `RESP_DATA1`=3 (charge).
- `send_resp_done`, in, 1: one-cycle pulse from the response generator.
- `phi_rd_req`, out, 1: one-cycle read request to the phi source.
- `chrg_rd_req`, out, 1: one-cycle read request to the charge source.
- `rd_addr`, out, `ADDR_WID`: read address; stable from the request cycle until `send_resp_done`.
- `go_pulse`, out, 1: one-cycle simulation start.

## Operation
- Reset value of every output is 0. The state after reset is `IDLE`.
- States:
  - `IDLE`, `CMD1`, `CMD2`: command characters.
  - `ARG`: hex digits, counted by `dig_cnt`, which holds 0..`ADDR_DIG`.
  - `EOL`: expect CR.
  - `FLUSH`: error seen; discard until CR.
  - `RESP`: handshake in progress.
- Echo:
  - Every `rx_data_rdy` outside `RESP` produces `send_char_val` with `send_char` = `rx_data`.
  - Characters arriving in `RESP` are dropped: not echoed, not parsed.
- `IDLE` transitions:
  - `*` → `CMD1`.
  - CR → stay in `IDLE`; no response (empty line).
  - Any other character → `FLUSH`.
- `CMD1`:
  - `G` → `CMD2`, with op GO.
  - `R` → `CMD2`, with op READ.
  - Any other character → `FLUSH`.
- `CMD2`:
  - Op GO: `O` → `EOL`.
  - Op READ: `P` or `C` → `ARG` (target recorded), `dig_cnt` cleared, address register cleared.
  - Any other character → `FLUSH`.
- `ARG`:
  - Hex digit: address shifts left 4 and the nibble is ORed in; `dig_cnt++`.
  - When `dig_cnt` reaches `ADDR_DIG` → `EOL`.
  - CR before all digits (short) → `RESP` with ERR.
  - Non-hex character → `FLUSH`.
- `EOL`:
  - CR → `RESP` with the command's response.
  - Any other character (including an extra digit) → `FLUSH`.
- `FLUSH`: CR → `RESP` with ERR.
- CR in any non-`IDLE` parse state (`CMD1`, `CMD2`, or `EOL` when mismatched) → `RESP` with ERR.
- Entering `RESP`:
  - `send_resp_val`=1 and `send_resp_type` set.
  - GO: `go_pulse` for 1 cycle, type OK.
  - RP: `phi_rd_req` for 1 cycle, type DATA0.
  - RC: `chrg_rd_req` for 1 cycle, type DATA1.
- In `RESP`, `send_resp_done`=1 → `send_resp_val` drops the next cycle and the state returns to `IDLE`.
- `send_resp_type` and `rd_addr` are held constant throughout `RESP`.
- Accepted characters are `0-9`, `A-F`, `G`, `O`, `R`, `P`, `C`, `*`, and CR (0x0D), all uppercase only (see Configuration).

## Timing
- `rx_data_rdy` in cycle N → `send_char_val` in cycle N+1. Echo is registered.
- Terminating CR in cycle N:
  - `send_resp_val`, the request pulse and `go_pulse` assert in cycle N+1.
  - The echo of the CR is also in cycle N+1. The response generator pushes it before it leaves idle.
- `send_resp_done` in cycle M → `send_resp_val`=0 in M+1.
- A character arriving in cycle M is dropped. A character arriving in M+1 is parsed.
- `rst` mid-command or mid-`RESP`:
  - Next cycle all outputs are 0 and the state is `IDLE`.
  - A pending done is ignored.
- There is no backpressure toward the UART. One character per cycle is sustainable.

## Configuration
- `UI_CMD_LOWERCASE_EN` defined:
  - Command letters and hex digits `a-f` are also accepted, case-insensitive.
  - The echo is unchanged: the received case is echoed.
- `UI_CMD_LOWERCASE_EN` undefined: any lowercase character is a parse error → `FLUSH`.

## Structure
- Package `ui_pkg` holds:
  - `RESP_OK`, `RESP_ERR`, `RESP_DATA0`, `RESP_DATA1` (shared with the response generator).
  - Character constants: `CHAR_CR`=8'h0D and `CHAR_STAR`.
  - The parser state enum.
- Sub-module `ui_hex_decode`: combinational character → {valid, nibble}. It honours `UI_CMD_LOWERCASE_EN`.

## Test plan
- `*GO`+CR: 4 echoes in order; `go_pulse` for 1 cycle; `send_resp_val` with type 0 until done; val low 1 cycle after done.
- `*RP12AB`+CR: `phi_rd_req` 1 cycle; `rd_addr`=16'h12AB; type 2; held until done.
- `*RC00F` followed by CR (3 digits): type 1 (ERR), no `chrg_rd_req`.
- `*RCX99`+CR: `FLUSH` on `X`; a single ERR only at CR.
- Characters sent while in `RESP`: no echo; the following valid `*RC0001`+CR yields `chrg_rd_req` with `rd_addr`=1.
- `*rp00ff`+CR: ERR without `UI_CMD_LOWERCASE_EN`; DATA0 with `rd_addr`=16'h00FF when it is defined.
- Reset asserted in the middle of `RESP`: all outputs 0 the next cycle.

Source files
------------

// File: rtl/ui_pkg.sv
// Shared constants and types for the serial UI command path.
// Lowercase command acceptance is controlled by UI_CMD_LOWERCASE_EN.
package ui_pkg;

  localparam logic [1:0] RESP_OK    = 2'd0;
  localparam logic [1:0] RESP_ERR   = 2'd1;
  localparam logic [1:0] RESP_DATA0 = 2'd2;
  localparam logic [1:0] RESP_DATA1 = 2'd3;

  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_STAR  = 8'h2A;
  localparam logic [7:0] CHAR_0     = 8'h30;
  localparam logic [7:0] CHAR_9     = 8'h39;
  localparam logic [7:0] CHAR_A     = 8'h41;
  localparam logic [7:0] CHAR_C     = 8'h43;
  localparam logic [7:0] CHAR_F     = 8'h46;
  localparam logic [7:0] CHAR_G     = 8'h47;
  localparam logic [7:0] CHAR_O     = 8'h4F;
  localparam logic [7:0] CHAR_P     = 8'h50;
  localparam logic [7:0] CHAR_R     = 8'h52;
  localparam logic [7:0] CHAR_LC_A  = 8'h61;
  localparam logic [7:0] CHAR_LC_F  = 8'h66;
  localparam logic [7:0] CHAR_LC_Z  = 8'h7A;

  typedef logic [2:0] parse_state_t;
  localparam parse_state_t ST_IDLE  = 3'd0;
  localparam parse_state_t ST_CMD1  = 3'd1;
  localparam parse_state_t ST_CMD2  = 3'd2;
  localparam parse_state_t ST_ARG   = 3'd3;
  localparam parse_state_t ST_EOL   = 3'd4;
  localparam parse_state_t ST_FLUSH = 3'd5;
  localparam parse_state_t ST_RESP  = 3'd6;

  typedef enum logic {OP_GO = 1'b0, OP_READ = 1'b1} op_t;
  typedef enum logic {TGT_PHI = 1'b0, TGT_CHRG = 1'b1} tgt_t;

  // Folds lowercase letters onto uppercase only when lowercase input is allowed.
  function automatic logic [7:0] cmd_char(input logic [7:0] c);
`ifdef UI_CMD_LOWERCASE_EN
    if (c >= CHAR_LC_A && c <= CHAR_LC_Z) return c - 8'h20;
`endif
    return c;
  endfunction

endpackage

// File: rtl/ui_hex_decode.sv
// Combinational ASCII hex digit decoder: character -> {valid, nibble}.
// Accepts a-f in addition to A-F when UI_CMD_LOWERCASE_EN is defined.
module ui_hex_decode (
  input  logic [7:0] ch_i,
  output logic       valid_o,
  output logic [3:0] nib_o
);
  import ui_pkg::*;

  always_comb begin
    valid_o = 1'b0;
    nib_o   = '0;
    if (ch_i >= CHAR_0 && ch_i <= CHAR_9) begin
      valid_o = 1'b1;
      nib_o   = ch_i[3:0];
    end else if (ch_i >= CHAR_A && ch_i <= CHAR_F) begin
      valid_o = 1'b1;
      nib_o   = ch_i[3:0] + 4'd9;
    end
`ifdef UI_CMD_LOWERCASE_EN
    else if (ch_i >= CHAR_LC_A && ch_i <= CHAR_LC_F) begin
      valid_o = 1'b1;
      nib_o   = ch_i[3:0] + 4'd9;
    end
`endif
  end

endmodule

// File: rtl/ui_cmd_parse.sv
// Receive-side command parser: echoes characters, decodes *GO / *RPaaaa / *RCaaaa,
// and drives the response handshake. Lowercase input enabled by UI_CMD_LOWERCASE_EN.
module ui_cmd_parse #(
  parameter int unsigned ADDR_WID = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_data_rdy,
  output logic                send_char_val,
  output logic [7:0]          send_char,
  output logic                send_resp_val,
  output logic [1:0]          send_resp_type,
  input  logic                send_resp_done,
  output logic                phi_rd_req,
  output logic                chrg_rd_req,
  output logic [ADDR_WID-1:0] rd_addr,
  output logic                go_pulse
);
  import ui_pkg::*;

  localparam int unsigned ADDR_DIG = ADDR_WID / 4;
  localparam int unsigned CNT_W    = $clog2(ADDR_DIG + 1);

  parse_state_t        state_q, state_d;
  op_t                 op_q, op_d;
  tgt_t                tgt_q, tgt_d;
  logic [CNT_W-1:0]    dig_cnt_q, dig_cnt_d;
  logic [ADDR_WID-1:0] addr_q, addr_d;
  logic                echo_val_q, echo_val_d;
  logic [7:0]          echo_char_q, echo_char_d;
  logic                resp_val_q, resp_val_d;
  logic [1:0]          resp_type_q, resp_type_d;
  logic                phi_req_q, phi_req_d;
  logic                chrg_req_q, chrg_req_d;
  logic                go_q, go_d;

  logic                hex_val;
  logic [3:0]          hex_nib;
  logic [7:0]          cmd_ch;
  logic [CNT_W-1:0]    dig_nxt;

  ui_hex_decode u_hex (
    .ch_i    (rx_data),
    .valid_o (hex_val),
    .nib_o   (hex_nib)
  );

  assign cmd_ch  = cmd_char(rx_data);
  assign dig_nxt = dig_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    tgt_d       = tgt_q;
    dig_cnt_d   = dig_cnt_q;
    addr_d      = addr_q;
    echo_val_d  = 1'b0;
    echo_char_d = echo_char_q;
    resp_val_d  = resp_val_q;
    resp_type_d = resp_type_q;
    phi_req_d   = 1'b0;
    chrg_req_d  = 1'b0;
    go_d        = 1'b0;

    if (state_q == ST_RESP) begin
      if (send_resp_done) begin
        resp_val_d = 1'b0;
        state_d    = ST_IDLE;
      end
    end else if (rx_data_rdy) begin
      echo_val_d  = 1'b1;
      echo_char_d = rx_data;
      if (rx_data == CHAR_CR) begin
        // A CR anywhere but IDLE ends the line; only EOL carries a good command.
        if (state_q != ST_IDLE) begin
          state_d     = ST_RESP;
          resp_val_d  = 1'b1;
          resp_type_d = RESP_ERR;
          if (state_q == ST_EOL) begin
            if (op_q == OP_GO) begin
              resp_type_d = RESP_OK;
              go_d        = 1'b1;
            end else if (tgt_q == TGT_PHI) begin
              resp_type_d = RESP_DATA0;
              phi_req_d   = 1'b1;
            end else begin
              resp_type_d = RESP_DATA1;
              chrg_req_d  = 1'b1;
            end
          end
        end
      end else begin
        case (state_q)
          ST_IDLE: state_d = (rx_data == CHAR_STAR) ? ST_CMD1 : ST_FLUSH;
          ST_CMD1: begin
            if (cmd_ch == CHAR_G) begin
              state_d = ST_CMD2;
              op_d    = OP_GO;
            end else if (cmd_ch == CHAR_R) begin
              state_d = ST_CMD2;
              op_d    = OP_READ;
            end else begin
              state_d = ST_FLUSH;
            end
          end
          ST_CMD2: begin
            if (op_q == OP_GO && cmd_ch == CHAR_O) begin
              state_d = ST_EOL;
            end else if (op_q == OP_READ && (cmd_ch == CHAR_P || cmd_ch == CHAR_C)) begin
              state_d   = ST_ARG;
              tgt_d     = (cmd_ch == CHAR_P) ? TGT_PHI : TGT_CHRG;
              dig_cnt_d = '0;
              addr_d    = '0;
            end else begin
              state_d = ST_FLUSH;
            end
          end
          ST_ARG: begin
            if (hex_val) begin
              addr_d    = (addr_q << 4) | ADDR_WID'(hex_nib);
              dig_cnt_d = dig_nxt;
              if (dig_nxt == CNT_W'(ADDR_DIG)) state_d = ST_EOL;
            end else begin
              state_d = ST_FLUSH;
            end
          end
          default: state_d = ST_FLUSH;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_GO;
      tgt_q       <= TGT_PHI;
      dig_cnt_q   <= '0;
      addr_q      <= '0;
      echo_val_q  <= 1'b0;
      echo_char_q <= '0;
      resp_val_q  <= 1'b0;
      resp_type_q <= '0;
      phi_req_q   <= 1'b0;
      chrg_req_q  <= 1'b0;
      go_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      tgt_q       <= tgt_d;
      dig_cnt_q   <= dig_cnt_d;
      addr_q      <= addr_d;
      echo_val_q  <= echo_val_d;
      echo_char_q <= echo_char_d;
      resp_val_q  <= resp_val_d;
      resp_type_q <= resp_type_d;
      phi_req_q   <= phi_req_d;
      chrg_req_q  <= chrg_req_d;
      go_q        <= go_d;
    end
  end

  assign send_char_val  = echo_val_q;
  assign send_char      = echo_char_q;
  assign send_resp_val  = resp_val_q;
  assign send_resp_type = resp_type_q;
  assign phi_rd_req     = phi_req_q;
  assign chrg_rd_req    = chrg_req_q;
  assign rd_addr        = addr_q;
  assign go_pulse       = go_q;

endmodule

// File: tb/tb_ui_cmd_parse.sv
// Directed bench for ui_cmd_parse: table of command lines plus hand-written
// sequences for empty lines, characters during RESP and reset mid-RESP.
module tb_ui_cmd_parse;
  import ui_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_data_rdy = 1'b0;
  logic        send_char_val;
  logic [7:0]  send_char;
  logic        send_resp_val;
  logic [1:0]  send_resp_type;
  logic        send_resp_done = 1'b0;
  logic        phi_rd_req;
  logic        chrg_rd_req;
  logic [15:0] rd_addr;
  logic        go_pulse;

  always #5 clk = ~clk;

  ui_cmd_parse #(.ADDR_WID(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_data_rdy    (rx_data_rdy),
    .send_char_val  (send_char_val),
    .send_char      (send_char),
    .send_resp_val  (send_resp_val),
    .send_resp_type (send_resp_type),
    .send_resp_done (send_resp_done),
    .phi_rd_req     (phi_rd_req),
    .chrg_rd_req    (chrg_rd_req),
    .rd_addr        (rd_addr),
    .go_pulse       (go_pulse)
  );

  // req: 0 none, 1 go, 2 phi, 3 chrg
  typedef struct {
    logic [79:0] cmd;
    int          len;
    logic [1:0]  typ;
    int          req;
    bit          chk_addr;
    logic [15:0] addr;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;

  int n_go = 0, n_phi = 0, n_chrg = 0, n_rise = 0;
  logic prev_val = 1'b0;
  logic [7:0] echo_q[$];

  int s_go, s_phi, s_chrg, s_rise, s_echo;

  always @(negedge clk) begin
    if (go_pulse)    n_go   <= n_go + 1;
    if (phi_rd_req)  n_phi  <= n_phi + 1;
    if (chrg_rd_req) n_chrg <= n_chrg + 1;
    if (send_resp_val && !prev_val) n_rise <= n_rise + 1;
    prev_val <= send_resp_val;
    if (send_char_val) echo_q.push_back(send_char);
  end

  function automatic vec_t mk(input logic [79:0] c, input int l, input logic [1:0] t,
                              input int r, input bit ca, input logic [15:0] a);
    vec_t v;
    v.cmd = c; v.len = l; v.typ = t; v.req = r; v.chk_addr = ca; v.addr = a;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_line(input vec_t v);
    s_go = n_go; s_phi = n_phi; s_chrg = n_chrg; s_rise = n_rise; s_echo = echo_q.size();
    for (int i = 0; i < v.len; i++) begin
      @(posedge clk); #1;
      rx_data = v.cmd[8*(v.len-1-i) +: 8];
      rx_data_rdy = 1'b1;
    end
    @(posedge clk); #1;
    rx_data = CHAR_CR;
    rx_data_rdy = 1'b1;
    @(posedge clk); #1;
    rx_data_rdy = 1'b0;
  endtask

  task automatic check_echo(input string t, input vec_t v);
    int bad;
    logic [7:0] exp_c;
    bad = 0;
    chk({t, "_echo_len"}, echo_q.size() - s_echo, v.len + 1);
    if (echo_q.size() - s_echo == v.len + 1) begin
      for (int i = 0; i <= v.len; i++) begin
        exp_c = (i == v.len) ? CHAR_CR : v.cmd[8*(v.len-1-i) +: 8];
        if (echo_q[s_echo + i] !== exp_c) bad++;
      end
    end
    chk({t, "_echo_data"}, bad, 0);
  endtask

  task automatic check_resp(input vec_t v, input int idx, input bit junk);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, "_val_rise"}, send_resp_val, 1);
    chk({t, "_type"}, send_resp_type, v.typ);
    if (v.chk_addr) chk({t, "_addr"}, rd_addr, v.addr);
    repeat (3) @(posedge clk);
    #1;
    chk({t, "_val_hold"}, send_resp_val, 1);
    chk({t, "_type_hold"}, send_resp_type, v.typ);
    if (v.chk_addr) chk({t, "_addr_hold"}, rd_addr, v.addr);
    send_resp_done = 1'b1;
    if (junk) begin
      rx_data = "Q";
      rx_data_rdy = 1'b1;
    end
    @(posedge clk); #1;
    send_resp_done = 1'b0;
    rx_data_rdy = 1'b0;
    chk({t, "_val_drop"}, send_resp_val, 0);
    repeat (2) @(posedge clk);
    #1;
    chk({t, "_reqs"}, {8'(n_go - s_go), 8'(n_phi - s_phi), 8'(n_chrg - s_chrg)},
        {8'(v.req == 1), 8'(v.req == 2), 8'(v.req == 3)});
    chk({t, "_one_resp"}, n_rise - s_rise, 1);
    check_echo(t, v);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = mk("*GO",      3, RESP_OK,    1, 1'b0, 16'h0000);
    vecs[1]  = mk("*RP12AB",  7, RESP_DATA0, 2, 1'b1, 16'h12AB);
    vecs[2]  = mk("*RC00F",   6, RESP_ERR,   0, 1'b0, 16'h0000);
    vecs[3]  = mk("*RCX99",   6, RESP_ERR,   0, 1'b0, 16'h0000);
    vecs[4]  = mk("*RC0001",  7, RESP_DATA1, 3, 1'b1, 16'h0001);
`ifdef UI_CMD_LOWERCASE_EN
    vecs[5]  = mk("*rp00ff",  7, RESP_DATA0, 2, 1'b1, 16'h00FF);
`else
    vecs[5]  = mk("*rp00ff",  7, RESP_ERR,   0, 1'b0, 16'h0000);
`endif
    vecs[6]  = mk("*RP12345", 8, RESP_ERR,   0, 1'b0, 16'h0000);
    vecs[7]  = mk("*G",       2, RESP_ERR,   0, 1'b0, 16'h0000);
    vecs[8]  = mk("*",        1, RESP_ERR,   0, 1'b0, 16'h0000);
    vecs[9]  = mk("XYZ",      3, RESP_ERR,   0, 1'b0, 16'h0000);
    vecs[10] = mk("*RPFFFF",  7, RESP_DATA0, 2, 1'b1, 16'hFFFF);
    vecs[11] = mk("*GOO",     4, RESP_ERR,   0, 1'b0, 16'h0000);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_resp_val", send_resp_val, 0);
    chk("rst_resp_type", send_resp_type, 0);
    chk("rst_echo", {send_char_val, send_char}, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_pulses", {go_pulse, phi_rd_req, chrg_rd_req}, 0);

    for (int i = 0; i < NV; i++) begin
      send_line(vecs[i]);
      check_resp(vecs[i], i, 1'b0);
    end

    // Empty line: echoed, no response.
    v = mk("", 0, RESP_OK, 0, 1'b0, 16'h0000);
    send_line(v);
    repeat (3) @(posedge clk);
    #1;
    chk("empty_no_resp", n_rise - s_rise, 0);
    chk("empty_val", send_resp_val, 0);
    check_echo("empty", v);

    // Characters during RESP (including the done cycle) are dropped.
    v = mk("*RP0010", 7, RESP_DATA0, 2, 1'b1, 16'h0010);
    send_line(v);
    rx_data = "Z";
    rx_data_rdy = 1'b1;
    @(posedge clk); #1;
    rx_data = CHAR_STAR;
    @(posedge clk); #1;
    rx_data_rdy = 1'b0;
    check_resp(v, 100, 1'b1);
    send_line(vecs[4]);
    check_resp(vecs[4], 101, 1'b0);

    // Reset during RESP with a coincident done.
    send_line(vecs[1]);
    chk("pre_rst_val", send_resp_val, 1);
    rst = 1'b1;
    send_resp_done = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send_resp_done = 1'b0;
    chk("midrst_resp_val", send_resp_val, 0);
    chk("midrst_resp_type", send_resp_type, 0);
    chk("midrst_addr", rd_addr, 0);
    chk("midrst_echo", {send_char_val, send_char}, 0);
    chk("midrst_pulses", {go_pulse, phi_rd_req, chrg_rd_req}, 0);
    @(posedge clk); #1;
    send_line(vecs[0]);
    check_resp(vecs[0], 102, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
